frc_remote_scheduler: RTL and testbench
=======================================

// Module: frc_remote_scheduler
// PURPOSE
// - Shares the single remote force link among NUM_REQ force-cache requesters.
// - Issues one frc ticket per cycle, by round-robin, gated by beat credits returned from the network.
// - Tracks sub-packet packing (SUBPKT_PER_BEAT per AXIS beat), so each credit covers one emitted beat.
// - Raises last_transfer_to_remote once every requester reports done; sits upstream of the force burst packer.
// PARAMETERS
// - NUM_REQ         4   number of force requesters (2..8)
// - CREDITS         16  beat credits granted by the remote link at reset (1..255)
// - SUBPKT_PER_BEAT 4   sub-packets packed per AXIS beat (power of 2)
// - CW              8   credit counter width (holds 0..CREDITS)
// PORTS
// - clk                        in   1          clock
// - rst                        in   1          synchronous, active-high reset
// - i_start                    in   1          pulse: begin a force-return round (honoured in IDLE only)
// - i_req                      in   NUM_REQ    requester i holds one sub-packet ready
// - i_done                     in   NUM_REQ    requester i has no further sub-packets this round (level)
// - i_credit_return            in   1          one beat credit returned by the network this cycle
// - o_grant                    out  NUM_REQ    one-hot, combinational; requester i's sub-packet is taken this cycle
// - o_sel                      out  $clog2(NUM_REQ)  index of the granted requester (data mux select)
// - o_frc_ticket               out  1          |o_grant; qualifies the sub-packet to the packer
// - o_last_transfer_to_remote  out  1          registered 1-cycle pulse: flush the partial beat with the last flag
// - o_round_done               out  1          registered 1-cycle pulse at round end (with or without data)
// - o_credits                  out  CW         credits currently available
// - o_busy                     out  1          state != IDLE
// - o_credit_overflow          out  1          sticky error: a return would exceed CREDITS
// BEHAVIOUR
// - Reset: state=IDLE, rr_ptr=0, sub_cnt=0, any_sent=0, credits=CREDITS; all outputs 0 except o_credits=CREDITS.
// - States:
//   - IDLE: no grants; i_start -> RUN.
//   - RUN: arbitrate each cycle; when &i_done and ~|i_req -> FLUSH.
//   - FLUSH (1 cycle): next cycle o_round_done=1 and o_last_transfer_to_remote=any_sent; -> IDLE.
// - Eligibility: requester i is eligible iff i_req[i] and state==RUN, and (sub_cnt!=0 or credits!=0).
//   - sub_cnt!=0: the current beat is partially filled, so it rides on the credit already reserved.
// - Round-robin: search starts at rr_ptr; the first eligible index wraps modulo NUM_REQ.
//   - On a grant to index k, rr_ptr <= (k+1) mod NUM_REQ. rr_ptr holds when there is no grant.
//   - At most one grant per cycle. A requester granted this cycle may present its next sub-packet the next cycle.
// - Packing: each ticket does sub_cnt <= (sub_cnt+1) mod SUBPKT_PER_BEAT and sets any_sent=1.
//   - A ticket issued with sub_cnt==0 reserves (consumes) one credit.
// - Credits, same cycle: consume & return -> unchanged; return only -> +1; consume only -> -1.
//   - A return at credits==CREDITS with no consume: hold the value and set o_credit_overflow.
//   - credits never underflows, because the eligibility gate prevents it.
// - i_start outside IDLE is ignored. i_req/i_done outside RUN are ignored.
// - On FLUSH exit: sub_cnt=0 and any_sent=0. Credits are not restored; the network returns them.
// - Beat count per round = ceil(tickets/SUBPKT_PER_BEAT). It equals the credits consumed.
// - rst mid-round: immediate return to reset values. No last pulse is generated.
// TESTING
// - Reset, then i_start, all 4 i_req=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3; credits 16->14; sub_cnt back to 0.
// - CREDITS=1, no returns, req0 held -> 4 tickets, then tickets stall (sub_cnt=0, credits=0); one i_credit_return -> ticket resumes next cycle.
// - 5 tickets, then all i_done with i_req=0 -> FLUSH; next cycle last=1 and round_done=1 for one cycle; credits consumed=2.
// - i_start, then immediately all i_done with no req -> round_done pulse, last stays 0, credits unchanged.
// - Consume and i_credit_return in the same cycle at credits=5 -> stays 5; return at credits=16 idle -> stays 16, overflow=1 sticky.
// - rst asserted mid-RUN with sub_cnt=2 -> next cycle IDLE, o_grant=0, credits=CREDITS, no last pulse.

Source files
------------

// File: rtl/frc_remote_scheduler.sv
// rtl/frc_remote_scheduler.sv - credit-gated round-robin ticket issuer for the remote force link
// One sub-packet ticket per cycle; a credit is reserved only when a ticket opens a new beat.
module frc_remote_scheduler #(
  parameter int NUM_REQ         = 4,
  parameter int CREDITS         = 16,
  parameter int SUBPKT_PER_BEAT = 4,
  parameter int CW              = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [NUM_REQ-1:0]         i_done,
  input  logic                       i_credit_return,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_sel,
  output logic                       o_frc_ticket,
  output logic                       o_last_transfer_to_remote,
  output logic                       o_round_done,
  output logic [CW-1:0]              o_credits,
  output logic                       o_busy,
  output logic                       o_credit_overflow
);

  localparam int SW  = $clog2(NUM_REQ);
  localparam int SWP = SW + 1;
  localparam int SCW = (SUBPKT_PER_BEAT > 1) ? $clog2(SUBPKT_PER_BEAT) : 1;
  localparam logic [CW-1:0]  CRED_MAX = CW'(CREDITS);
  localparam logic [SW-1:0]  LAST_IDX = SW'(NUM_REQ - 1);
  localparam logic [SCW-1:0] SUB_LAST = SCW'(SUBPKT_PER_BEAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SCW-1:0] sub_cnt_q, sub_cnt_d;
  logic           any_sent_q, any_sent_d;
  logic [CW-1:0]  credits_q, credits_d;
  logic           ovf_q, ovf_d;
  logic           last_q, last_d;
  logic           round_done_q, round_done_d;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] rot;
  logic               found;
  logic [SW-1:0]      sel;
  logic [SWP-1:0]     idx_sum;
  logic               consume;

  // A partially filled beat rides on its already-reserved credit, so only a fresh beat needs credits!=0.
  always_comb begin
    elig    = '0;
    rot     = '0;
    found   = 1'b0;
    sel     = '0;
    idx_sum = '0;
    if (state_q == ST_RUN && (sub_cnt_q != '0 || credits_q != '0)) begin
      elig = i_req;
    end
    rot = NUM_REQ'({elig, elig} >> rr_ptr_q);
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && rot[j]) begin
        found   = 1'b1;
        idx_sum = {1'b0, rr_ptr_q} + SWP'(j);
        if (idx_sum >= SWP'(NUM_REQ)) begin
          idx_sum = idx_sum - SWP'(NUM_REQ);
        end
        sel = idx_sum[SW-1:0];
      end
    end
  end

  assign consume      = found && (sub_cnt_q == '0);
  assign o_grant      = found ? (NUM_REQ'(1'b1) << sel) : '0;
  assign o_sel        = sel;
  assign o_frc_ticket = found;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    sub_cnt_d    = sub_cnt_q;
    any_sent_d   = any_sent_q;
    credits_d    = credits_q;
    ovf_d        = ovf_q;
    last_d       = 1'b0;
    round_done_d = 1'b0;

    if (found) begin
      rr_ptr_d   = (sel == LAST_IDX) ? '0 : sel + 1'b1;
      sub_cnt_d  = (sub_cnt_q == SUB_LAST) ? '0 : sub_cnt_q + 1'b1;
      any_sent_d = 1'b1;
    end

    if (consume && !i_credit_return) begin
      credits_d = credits_q - 1'b1;
    end else if (!consume && i_credit_return) begin
      if (credits_q == CRED_MAX) begin
        ovf_d = 1'b1;
      end else begin
        credits_d = credits_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if ((&i_done) && !(|i_req)) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        state_d      = ST_IDLE;
        round_done_d = 1'b1;
        last_d       = any_sent_q;
        sub_cnt_d    = '0;
        any_sent_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      sub_cnt_q    <= '0;
      any_sent_q   <= 1'b0;
      credits_q    <= CRED_MAX;
      ovf_q        <= 1'b0;
      last_q       <= 1'b0;
      round_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      sub_cnt_q    <= sub_cnt_d;
      any_sent_q   <= any_sent_d;
      credits_q    <= credits_d;
      ovf_q        <= ovf_d;
      last_q       <= last_d;
      round_done_q <= round_done_d;
    end
  end

  assign o_last_transfer_to_remote = last_q;
  assign o_round_done              = round_done_q;
  assign o_credits                 = credits_q;
  assign o_busy                    = (state_q != ST_IDLE);
  assign o_credit_overflow         = ovf_q;

endmodule

// File: tb/tb_frc_remote_scheduler.sv
// tb/tb_frc_remote_scheduler.sv - bench for frc_remote_scheduler
// Ticket-count reference model plus directed vector table and corner sequences.
module tb_frc_remote_scheduler;

  localparam int N    = 4;
  localparam int CRED = 16;
  localparam int SPB  = 4;
  localparam int CW   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, ret = 1'b0;
  logic [N-1:0] req = '0, done = '0;
  logic [N-1:0] grant;
  logic [1:0] sel;
  logic ticket, last, rd, busy, ovf;
  logic [CW-1:0] credits;

  logic start1 = 1'b0, ret1 = 1'b0;
  logic [N-1:0] req1 = '0, done1 = '0;
  logic [N-1:0] grant1;
  logic [1:0] sel1;
  logic ticket1, last1, rd1, busy1, ovf1;
  logic [CW-1:0] credits1;

  always #5 clk = ~clk;

  frc_remote_scheduler #(.NUM_REQ(N), .CREDITS(CRED), .SUBPKT_PER_BEAT(SPB), .CW(CW)) u_dut (
    .clk(clk), .rst(rst), .i_start(start), .i_req(req), .i_done(done),
    .i_credit_return(ret), .o_grant(grant), .o_sel(sel), .o_frc_ticket(ticket),
    .o_last_transfer_to_remote(last), .o_round_done(rd), .o_credits(credits),
    .o_busy(busy), .o_credit_overflow(ovf)
  );

  frc_remote_scheduler #(.NUM_REQ(N), .CREDITS(1), .SUBPKT_PER_BEAT(SPB), .CW(CW)) u_dut1 (
    .clk(clk), .rst(rst), .i_start(start1), .i_req(req1), .i_done(done1),
    .i_credit_return(ret1), .o_grant(grant1), .o_sel(sel1), .o_frc_ticket(ticket1),
    .o_last_transfer_to_remote(last1), .o_round_done(rd1), .o_credits(credits1),
    .o_busy(busy1), .o_credit_overflow(ovf1)
  );

  int checks = 0;
  int errors = 0;

  // Reference: 0 idle, 1 run, 2 flush; m_tick counts tickets issued this round.
  int m_state, m_rr, m_tick, m_cred;
  bit m_ovf, m_last, m_rd;
  logic [N-1:0] obs_grant;

  typedef struct {
    bit          st;
    logic [N-1:0] rq;
    logic [N-1:0] dn;
    logic [N-1:0] eg;
    int          ec;
    bit          eb;
    bit          el;
    bit          erd;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_rr = 0; m_tick = 0; m_cred = CRED;
    m_ovf = 0; m_last = 0; m_rd = 0;
  endtask

  function automatic int model_grant(input logic [N-1:0] rq);
    if (m_state != 1) return -1;
    if ((m_tick % SPB) == 0 && m_cred == 0) return -1;
    for (int off = 0; off < N; off++) begin
      if (rq[(m_rr + off) % N]) return (m_rr + off) % N;
    end
    return -1;
  endfunction

  task automatic tick(input bit st, input logic [N-1:0] rq, input logic [N-1:0] dn,
                      input bit rt, input bit rs);
    int g;
    bit cons;
    logic [N-1:0] eg;
    rst = rs; start = st; req = rq; done = dn; ret = rt;
    #1;
    g = model_grant(rq);
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    obs_grant = grant;
    chk("grant", 32'(grant), 32'(eg));
    chk("ticket", 32'(ticket), 32'(g >= 0));
    if (g >= 0) chk("sel", 32'(sel), 32'(g));
    chk("credits", 32'(credits), 32'(m_cred));
    chk("busy", 32'(busy), 32'(m_state != 0));
    chk("last", 32'(last), 32'(m_last));
    chk("round_done", 32'(rd), 32'(m_rd));
    chk("overflow", 32'(ovf), 32'(m_ovf));
    if (rs) begin
      model_reset();
    end else begin
      cons = 0;
      if (g >= 0) begin
        cons = ((m_tick % SPB) == 0);
        m_tick++;
        m_rr = (g + 1) % N;
      end
      if (cons && !rt) m_cred--;
      else if (!cons && rt) begin
        if (m_cred == CRED) m_ovf = 1;
        else m_cred++;
      end
      m_last = 0; m_rd = 0;
      case (m_state)
        0: if (st) m_state = 1;
        1: if ((&dn) && rq == '0) m_state = 2;
        default: begin
          m_rd = 1; m_last = (m_tick > 0); m_tick = 0; m_state = 0;
        end
      endcase
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick(0, '0, '0, 0, 1);
    tick(0, '0, '0, 0, 1);
    tick(0, '0, '0, 0, 0);
  endtask

  initial begin
    logic [N-1:0] rq, dn;
    logic [N-1:0] g1_exp [8];

    tbl[0]  = '{1, 4'h0, 4'h0, 4'h0, 16, 0, 0, 0};
    tbl[1]  = '{0, 4'hF, 4'h0, 4'h1, 16, 1, 0, 0};
    tbl[2]  = '{0, 4'hF, 4'h0, 4'h2, 15, 1, 0, 0};
    tbl[3]  = '{0, 4'hF, 4'h0, 4'h4, 15, 1, 0, 0};
    tbl[4]  = '{0, 4'hF, 4'h0, 4'h8, 15, 1, 0, 0};
    tbl[5]  = '{0, 4'hF, 4'h0, 4'h1, 15, 1, 0, 0};
    tbl[6]  = '{0, 4'hF, 4'h0, 4'h2, 14, 1, 0, 0};
    tbl[7]  = '{0, 4'hF, 4'h0, 4'h4, 14, 1, 0, 0};
    tbl[8]  = '{0, 4'hF, 4'h0, 4'h8, 14, 1, 0, 0};
    tbl[9]  = '{0, 4'h0, 4'hF, 4'h0, 14, 1, 0, 0};
    tbl[10] = '{0, 4'h0, 4'hF, 4'h0, 14, 1, 0, 0};
    tbl[11] = '{0, 4'h0, 4'h0, 4'h0, 14, 0, 1, 1};
    tbl[12] = '{0, 4'h0, 4'h0, 4'h0, 14, 0, 0, 0};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);

    chk("rst_credits", 32'(credits), 32'(CRED));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_credits1", 32'(credits1), 32'd1);

    // Single-credit link: four sub-packets share one beat, then stall until a credit returns.
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    req1 = 4'h1;
    g1_exp = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h1};
    for (int c = 0; c < 8; c++) begin
      ret1 = (c == 5);
      #1;
      chk($sformatf("c1_grant%0d", c), 32'(grant1), 32'(g1_exp[c]));
      if (c == 4) chk("c1_stall_credits", 32'(credits1), 32'd0);
      if (c == 6) chk("c1_resume_credits", 32'(credits1), 32'd1);
      @(negedge clk);
    end
    req1 = '0; ret1 = 1'b0;

    do_reset();
    for (int i = 0; i < 13; i++) begin
      tick(tbl[i].st, tbl[i].rq, tbl[i].dn, 0, 0);
      chk($sformatf("tbl%0d_grant", i), 32'(obs_grant), 32'(tbl[i].eg));
    end
    do_reset();
    for (int i = 0; i < 13; i++) begin
      rst = 0; start = tbl[i].st; req = tbl[i].rq; done = tbl[i].dn; ret = 0;
      #1;
      chk($sformatf("tbl%0d_cred", i), 32'(credits), 32'(tbl[i].ec));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].eb));
      chk($sformatf("tbl%0d_last", i), 32'(last), 32'(tbl[i].el));
      chk($sformatf("tbl%0d_rd", i), 32'(rd), 32'(tbl[i].erd));
      @(negedge clk);
    end

    // Five tickets -> two beats, flush with last flag.
    rst = 1'b1; @(negedge clk); rst = 1'b0; model_reset();
    do_reset();
    tick(1, '0, '0, 0, 0);
    repeat (5) tick(0, 4'h1, '0, 0, 0);
    tick(0, '0, 4'hF, 0, 0);
    tick(0, '0, 4'hF, 0, 0);
    chk("five_last", 32'(last), 32'd1);
    chk("five_rd", 32'(rd), 32'd1);
    chk("five_credits", 32'(credits), 32'd14);
    tick(0, '0, '0, 0, 0);
    chk("five_last_clear", 32'(last), 32'd0);

    // Empty round: done pulse without last.
    do_reset();
    tick(1, '0, '0, 0, 0);
    tick(0, '0, 4'hF, 0, 0);
    tick(0, '0, 4'hF, 0, 0);
    chk("empty_rd", 32'(rd), 32'd1);
    chk("empty_last", 32'(last), 32'd0);
    chk("empty_credits", 32'(credits), 32'(CRED));

    // Consume plus return at credits=5.
    do_reset();
    tick(1, '0, '0, 0, 0);
    repeat (44) tick(0, 4'h1, '0, 0, 0);
    chk("c5_before", 32'(credits), 32'd5);
    tick(0, 4'h1, '0, 1, 0);
    chk("c5_after", 32'(credits), 32'd5);

    // Return while full: hold and flag overflow, sticky.
    do_reset();
    tick(0, '0, '0, 1, 0);
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_credits", 32'(credits), 32'(CRED));
    tick(0, '0, '0, 0, 0);
    chk("ovf_sticky", 32'(ovf), 32'd1);

    // Reset mid-round with sub_cnt=2.
    do_reset();
    tick(1, '0, '0, 0, 0);
    repeat (2) tick(0, 4'hF, '0, 0, 0);
    tick(0, 4'hF, '0, 0, 1);
    rst = 0; #1;
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_credits", 32'(credits), 32'(CRED));
    @(negedge clk);
    repeat (2) tick(0, 4'hF, 4'hF, 0, 0);

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rq = N'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        dn = '1;
        if ($urandom_range(0, 1) == 0) rq = '0;
      end else begin
        dn = N'($urandom);
      end
      tick($urandom_range(0, 9) == 0, rq, dn, $urandom_range(0, 3) == 0,
           $urandom_range(0, 299) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
